// File: rtl/imem_loader_if.sv
// Byte-stream input plus instruction-memory write port of the program loader.
// Carries no logic; it only bundles the signals.
// slave = the loader; master = the byte source and the memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              write_enable;
    logic [15:0]       write_data;
    logic [ADDR_W-1:0] write_addr;

    modport master (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  write_enable,
        input  write_data,
        input  write_addr
    );

    modport slave (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output write_enable,
        output write_data,
        output write_addr
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-frame loader: parses ADDR/COUNT/DATA/CHK bytes and writes 16-bit words into instruction memory.
// Latency: a write strobe appears in the cycle after the low data byte; load_done appears one cycle after CHK.
// Backpressure: in_ready is low only in the single DONE cycle; in_valid low stalls the FSM indefinitely.
module imem_loader #(
    parameter int ADDR_W      = 32,
    parameter bit CHECKSUM_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    imem_loader_if.slave   bus,
    output logic           cpu_hold,
    output logic           load_done,
    output logic           load_error
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        COUNT,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE
    } state_t;

    state_t            state;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [15:0]       word_cnt;
    logic [7:0]        hi_byte;
    logic [7:0]        acc;
    logic              in_ready_r;
    logic              write_enable_r;
    logic [15:0]       write_data_r;
    logic [ADDR_W-1:0] write_addr_r;
    logic              fire;
    logic [15:0]       count_next;

    assign fire       = bus.in_valid && in_ready_r;
    // Full COUNT field as it looks once the low byte arrives.
    assign count_next = {word_cnt[7:0], bus.in_byte};

    assign bus.in_ready     = in_ready_r;
    assign bus.write_enable = write_enable_r;
    assign bus.write_data   = write_data_r;
    assign bus.write_addr   = write_addr_r;

    // Frame parser: one byte per transfer, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            byte_cnt       <= 2'd0;
            addr_cnt       <= '0;
            word_cnt       <= 16'd0;
            hi_byte        <= 8'd0;
            acc            <= 8'd0;
            in_ready_r     <= 1'b1;
            write_enable_r <= 1'b0;
            write_data_r   <= 16'd0;
            write_addr_r   <= '0;
            cpu_hold       <= 1'b1;
            load_done      <= 1'b0;
            load_error     <= 1'b0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            write_enable_r <= 1'b0;
            load_done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (fire) begin
                        // First address byte starts a new frame and re-holds the CPU.
                        addr_cnt   <= {{(ADDR_W-8){1'b0}}, bus.in_byte};
                        byte_cnt   <= 2'd0;
                        acc        <= 8'd0;
                        load_error <= 1'b0;
                        cpu_hold   <= 1'b1;
                        state      <= ADDR;
                    end
                end

                ADDR: begin
                    if (fire) begin
                        addr_cnt <= {addr_cnt[ADDR_W-9:0], bus.in_byte};
                        if (byte_cnt == 2'd2) begin
                            byte_cnt <= 2'd0;
                            state    <= COUNT;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end

                COUNT: begin
                    if (fire) begin
                        if (byte_cnt == 2'd0) begin
                            word_cnt <= {8'd0, bus.in_byte};
                            byte_cnt <= 2'd1;
                        end else begin
                            word_cnt <= count_next;
                            byte_cnt <= 2'd0;
                            state    <= (count_next == 16'd0) ? CHECK : DATA_HI;
                        end
                    end
                end

                DATA_HI: begin
                    if (fire) begin
                        hi_byte <= bus.in_byte;
                        acc     <= acc ^ bus.in_byte;
                        state   <= DATA_LO;
                    end
                end

                DATA_LO: begin
                    if (fire) begin
                        write_data_r   <= {hi_byte, bus.in_byte};
                        write_addr_r   <= addr_cnt;
                        write_enable_r <= 1'b1;
                        // Natural modulo-2^ADDR_W wrap of the word address.
                        addr_cnt       <= addr_cnt + 1'b1;
                        acc            <= acc ^ bus.in_byte;
                        word_cnt       <= word_cnt - 16'd1;
                        state          <= (word_cnt == 16'd1) ? CHECK : DATA_HI;
                    end
                end

                CHECK: begin
                    if (fire) begin
                        if ((bus.in_byte == acc) || !CHECKSUM_EN) begin
                            // DONE takes one cycle with no byte accepted.
                            in_ready_r <= 1'b0;
                            load_done  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            // Written words stay in memory; CPU remains held.
                            load_error <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end

                DONE: begin
                    cpu_hold   <= 1'b0;
                    in_ready_r <= 1'b1;
                    state      <= IDLE;
                end

                default: begin
                    state      <= IDLE;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (checksum on / off) share one byte driver.
// Inputs change 1 ns after the falling edge; outputs are sampled on the falling edge.
// A monitor logs every write strobe and load_done pulse for later comparison.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       drv_valid = 1'b0;
    logic [7:0] drv_byte = 8'd0;
    logic       sel = 1'b0;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(32)) bus_a ();
    imem_loader_if #(.ADDR_W(32)) bus_b ();

    assign bus_a.in_valid = drv_valid & ~sel;
    assign bus_a.in_byte  = drv_byte;
    assign bus_b.in_valid = drv_valid & sel;
    assign bus_b.in_byte  = drv_byte;

    logic hold_a, done_a, err_a;
    logic hold_b, done_b, err_b;

    imem_loader #(.ADDR_W(32), .CHECKSUM_EN(1'b1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_a),
        .cpu_hold   (hold_a),
        .load_done  (done_a),
        .load_error (err_a)
    );

    imem_loader #(.ADDR_W(32), .CHECKSUM_EN(1'b0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_b),
        .cpu_hold   (hold_b),
        .load_done  (done_b),
        .load_error (err_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Write / done log
    logic [31:0] wa_log [0:15];
    logic [15:0] wd_log [0:15];
    int wr_n = 0, done_n = 0, gap_bad = 0, wr_n_b = 0, done_n_b = 0;

    // Inputs are stable from 1 ns after one falling edge to 1 ns after the next,
    // so at a falling edge in_valid still shows what the preceding rising edge saw.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.write_enable) begin
                if (wr_n < 16) begin
                    wa_log[wr_n] = bus_a.write_addr;
                    wd_log[wr_n] = bus_a.write_data;
                end
                wr_n++;
                if (!bus_a.in_valid) gap_bad++;
            end
            if (done_a) done_n++;
            if (bus_b.write_enable) wr_n_b++;
            if (done_b) done_n_b++;
        end
    end

    task automatic clear_log();
        wr_n = 0; done_n = 0; gap_bad = 0; wr_n_b = 0; done_n_b = 0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drv_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        drv_valid = 1'b1;
        drv_byte  = b;
        while (!(sel ? bus_b.in_ready : bus_a.in_ready)) begin
            if (w >= 20) begin
                check("in_ready_wait", sel ? bus_b.in_ready : bus_a.in_ready, 1);
                break;
            end
            step();
            w++;
        end
        step();
    endtask

    logic [7:0] dat [0:15];

    task automatic send_frame(input logic [31:0] a, input int n, input logic [7:0] chk, input bit stall);
        logic [7:0] q [$];
        q = {};
        q.push_back(a[31:24]); q.push_back(a[23:16]);
        q.push_back(a[15:8]);  q.push_back(a[7:0]);
        q.push_back(8'(n >> 8)); q.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) q.push_back(dat[i]);
        q.push_back(chk);
        for (int i = 0; i < q.size(); i++) begin
            send_byte(q[i]);
            // Index 6 is the first DATA_HI byte: always leave a gap before its DATA_LO.
            if (stall) idle((i == 6) ? 2 : int'($urandom_range(0, 3)));
        end
        idle(4);
    endtask

    task automatic set_nominal();
        dat[0] = 8'h12; dat[1] = 8'h34; dat[2] = 8'hAB; dat[3] = 8'hCD;
    endtask

    task automatic check_nominal(input string tag);
        check({tag, "_wr_n"}, wr_n, 2);
        check({tag, "_addr0"}, wa_log[0], 32'h0000_0010);
        check({tag, "_data0"}, wd_log[0], 16'h1234);
        check({tag, "_addr1"}, wa_log[1], 32'h0000_0011);
        check({tag, "_data1"}, wd_log[1], 16'hABCD);
        check({tag, "_done"}, done_n, 1);
        check({tag, "_hold"}, hold_a, 0);
        check({tag, "_err"}, err_a, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus_a.in_ready, 1);
        check({tag, "_we"}, bus_a.write_enable, 0);
        check({tag, "_wdata"}, bus_a.write_data, 16'h0);
        check({tag, "_waddr"}, bus_a.write_addr, 32'h0);
        check({tag, "_hold"}, hold_a, 1);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_err"}, err_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Nominal frame, 1 byte per cycle; XOR of 12 34 AB CD is 0x40
        clear_log();
        set_nominal();
        send_frame(32'h0000_0010, 2, 8'h40, 1'b0);
        check_nominal("nominal");
        check("nominal_no_gap_we", gap_bad, 0);

        // Bad checksum: writes still land, error sticks, CPU held, no done
        clear_log();
        send_frame(32'h0000_0010, 2, 8'h00, 1'b0);
        check("badchk_wr_n", wr_n, 2);
        check("badchk_data1", wd_log[1], 16'hABCD);
        check("badchk_err", err_a, 1);
        check("badchk_hold", hold_a, 1);
        check("badchk_done", done_n, 0);

        // Following good frame clears the error and releases the CPU
        clear_log();
        send_frame(32'h0000_0010, 2, 8'h40, 1'b0);
        check_nominal("recover");

        // Address wrap; XOR of 01 02 03 04 is 0x04
        clear_log();
        dat[0] = 8'h01; dat[1] = 8'h02; dat[2] = 8'h03; dat[3] = 8'h04;
        send_frame(32'hFFFF_FFFF, 2, 8'h04, 1'b0);
        check("wrap_wr_n", wr_n, 2);
        check("wrap_addr0", wa_log[0], 32'hFFFF_FFFF);
        check("wrap_data0", wd_log[0], 16'h0102);
        check("wrap_addr1", wa_log[1], 32'h0000_0000);
        check("wrap_data1", wd_log[1], 16'h0304);
        check("wrap_done", done_n, 1);

        // Empty frame
        clear_log();
        send_frame(32'h0000_0100, 0, 8'h00, 1'b0);
        check("empty_wr_n", wr_n, 0);
        check("empty_done", done_n, 1);
        check("empty_hold", hold_a, 0);

        // Random in_valid gaps, including between DATA_HI and DATA_LO
        clear_log();
        set_nominal();
        send_frame(32'h0000_0010, 2, 8'h40, 1'b1);
        check_nominal("stall");
        check("stall_no_gap_we", gap_bad, 0);

        // Reset after the first DATA_HI byte
        clear_log();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        drv_valid = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        check("midrst_wr_n", wr_n, 0);
        check_reset_outputs("midrst");
        rst = 1'b0;
        step();
        clear_log();
        set_nominal();
        send_frame(32'h0000_0010, 2, 8'h40, 1'b0);
        check_nominal("after_rst");

        // Checksum checking disabled: wrong CHK still completes
        sel = 1'b1;
        step();
        clear_log();
        set_nominal();
        send_frame(32'h0000_0010, 2, 8'h55, 1'b0);
        check("nochk_wr_n", wr_n_b, 2);
        check("nochk_done", done_n_b, 1);
        check("nochk_err", err_b, 0);
        check("nochk_hold", hold_b, 0);
        check("nochk_a_idle_wr", wr_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
